// File: rtl/chip_test_scheduler.sv
// chip_test_scheduler: shares one Run/Done/RSLT panel among several chip testers.
module chip_test_scheduler #(
  parameter int NUM_CHIPS      = 16,
  parameter int SEL_W          = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int LAUNCH_GAP     = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic [SEL_W-1:0]     Chip_Sel,
  output logic [NUM_CHIPS-1:0] Chip_Run,
  input  logic [NUM_CHIPS-1:0] Chip_Done,
  input  logic [NUM_CHIPS-1:0] Chip_RSLT,
  output logic                 Busy,
  output logic                 Done,
  output logic                 RSLT,
  output logic                 Timeout,
  output logic                 Sel_Err,
  output logic [SEL_W-1:0]     Active_Sel,
  output logic [7:0]           Pass_Count,
  output logic [7:0]           Fail_Count
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW   = $clog2(LAUNCH_GAP + 1);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;
  state_t               state_q, state_d;
  logic                 run_prev_q;
  logic [GW-1:0]        gap_q, gap_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_CHIPS-1:0] run_q, run_d;
  logic                 busy_q, busy_d, done_q, done_d, rslt_q, rslt_d;
  logic                 to_q, to_d, serr_q, serr_d;
  logic [7:0]           pass_q, pass_d, fail_q, fail_d;
  logic                 start, bad_sel, hit, win, expire;
  always_comb begin
    start   = Run & ~run_prev_q;
    bad_sel = 32'(Chip_Sel) >= NUM_CHIPS;
    hit     = Chip_Done[sel_q];
    win     = hit & Chip_RSLT[sel_q];
    expire  = wd_q == WD_W'(TIMEOUT_CYCLES - 1);
    state_d = state_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    sel_d   = sel_q;
    done_d  = done_q;
    rslt_d  = rslt_q;
    to_d    = to_q;
    serr_d  = serr_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE, S_HOLD: if (start) begin
        sel_d   = Chip_Sel;
        done_d  = bad_sel;
        serr_d  = bad_sel;
        rslt_d  = 1'b0;
        to_d    = 1'b0;
        gap_d   = '0;
        state_d = bad_sel ? S_HOLD : S_LAUNCH;
      end
      S_LAUNCH: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(LAUNCH_GAP - 1)) begin
          state_d = S_WAIT;
          wd_d    = '0;
        end
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        // A Done arriving on the expiry cycle still counts as a real result.
        if (hit | expire) begin
          state_d = S_HOLD;
          done_d  = 1'b1;
          rslt_d  = win;
          to_d    = ~hit;
          pass_d  = pass_q + {7'd0, win & ~&pass_q};
          fail_d  = fail_q + {7'd0, ~win & ~&fail_q};
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT);
    run_d  = (state_d == S_WAIT) ? (NUM_CHIPS'(1) << sel_d) : '0;
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      run_prev_q <= 1'b1;
      gap_q      <= '0;
      wd_q       <= '0;
      sel_q      <= '0;
      run_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rslt_q     <= 1'b0;
      to_q       <= 1'b0;
      serr_q     <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      run_prev_q <= Run;
      gap_q      <= gap_d;
      wd_q       <= wd_d;
      sel_q      <= sel_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rslt_q     <= rslt_d;
      to_q       <= to_d;
      serr_q     <= serr_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end
  assign Chip_Run   = run_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign RSLT       = rslt_q;
  assign Timeout    = to_q;
  assign Sel_Err    = serr_q;
  assign Active_Sel = sel_q;
  assign Pass_Count = pass_q;
  assign Fail_Count = fail_q;
endmodule
